maze_bfs_solver: RTL and testbench

Parametrised breadth-first maze solver, the next generation of the team's fixed 15×15 maze runner. It loads a SIZE×SIZE wall bitmap serially and runs a true FIFO BFS from cell (1,1) to cell (SIZE-2,SIZE-2). It then streams the shortest path, goal to start, one coordinate per cycle, or flags the maze as unsolvable. It sits between the serial maze source and the path consumer in the maze pipeline.

---
 rtl/maze_bfs_solver.sv | 234 +++++++++++++++++++++++
 tb/tb_maze_bfs_solver.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_bfs_solver.sv
// Serial-loaded SIZE x SIZE maze, FIFO BFS from (1,1) to (SIZE-2,SIZE-2), path streamed goal-first.
// Define MAZE_PATH_LEN_EN to add the path_len output (start-to-goal step count).
module maze_bfs_solver #(
  parameter int unsigned SIZE        = 15,
  parameter int unsigned COORD_W     = $clog2(SIZE),
  parameter int unsigned QUEUE_DEPTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               maze,
  input  logic               in_valid,
  output logic               out_valid,
  output logic               maze_not_valid,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_last
`ifdef MAZE_PATH_LEN_EN
  ,
  output logic [2*COORD_W-1:0] path_len
`endif
);

  localparam int unsigned CELLS   = SIZE * SIZE;
  localparam int unsigned IDX_W   = $clog2(CELLS);
  localparam int unsigned QA_W    = $clog2(QUEUE_DEPTH);
  localparam int unsigned PTR_W   = QA_W + 1;
  localparam int unsigned OCC_W   = PTR_W + 2;
  localparam int unsigned CW2     = 2 * COORD_W;
  localparam int unsigned START_I = SIZE + 1;
  localparam int unsigned GOAL_I  = (SIZE - 2) * SIZE + (SIZE - 2);

  localparam logic [1:0] StLoad   = 2'd0;
  localparam logic [1:0] StSearch = 2'd1;
  localparam logic [1:0] StTrace  = 2'd2;
  localparam logic [1:0] StFail   = 2'd3;

  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);
  localparam logic [COORD_W-1:0] GOAL = COORD_W'(SIZE - 2);
  localparam logic [COORD_W-1:0] LAST = COORD_W'(SIZE - 1);
  localparam logic [CELLS-1:0]   START_MASK = CELLS'(1) << START_I;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] r,
                                                 input logic [COORD_W-1:0] c);
    return IDX_W'(r) * IDX_W'(SIZE) + IDX_W'(c);
  endfunction

  // Border cells are walls whatever was loaded.
  function automatic logic interior(input logic [COORD_W-1:0] r, input logic [COORD_W-1:0] c);
    return (r != '0) && (c != '0) && (r < LAST) && (c < LAST);
  endfunction

  logic [1:0]                      state_q;
  logic [IDX_W-1:0]                beat_q;
  logic [CELLS-1:0]                wall_q;
  logic [CELLS-1:0]                visited_q;
  logic [CELLS-1:0][1:0]           parent_q;
  logic [QUEUE_DEPTH-1:0][CW2-1:0] queue_q;
  logic [PTR_W-1:0]                head_q;
  logic [PTR_W-1:0]                tail_q;
  logic [COORD_W-1:0]              cur_r_q;
  logic [COORD_W-1:0]              cur_c_q;
  logic                            primed_q;
`ifdef MAZE_PATH_LEN_EN
  logic [CW2-1:0]                  step_q;
`endif

  logic [COORD_W-1:0]        deq_r;
  logic [COORD_W-1:0]        deq_c;
  logic [PTR_W-1:0]          occ;
  logic [3:0][COORD_W-1:0]   nb_r;
  logic [3:0][COORD_W-1:0]   nb_c;
  logic [3:0][IDX_W-1:0]     nb_idx;
  logic [3:0]                push_en;
  logic [3:0][PTR_W-1:0]     push_slot;
  logic [2:0]                n_push;
  logic                      goal_hit;
  logic                      overflow;
  logic                      blocked;
  logic                      accept;
  logic [IDX_W-1:0]          cur_idx;
  logic [COORD_W-1:0]        nxt_r;
  logic [COORD_W-1:0]        nxt_c;

  assign {deq_r, deq_c} = queue_q[head_q[QA_W-1:0]];
  assign occ     = tail_q - head_q;
  // Hold off the next maze until the final output beat has left.
  assign accept  = (state_q == StLoad) && in_valid && !out_valid;
  assign blocked = wall_q[IDX_W'(START_I)] || wall_q[IDX_W'(GOAL_I)];
  assign cur_idx = cell_idx(cur_r_q, cur_c_q);

  // Neighbour order: row+1, col+1, row-1, col-1; index k is also the stored parent code.
  assign nb_r[0] = deq_r + ONE;
  assign nb_c[0] = deq_c;
  assign nb_r[1] = deq_r;
  assign nb_c[1] = deq_c + ONE;
  assign nb_r[2] = deq_r - ONE;
  assign nb_c[2] = deq_c;
  assign nb_r[3] = deq_r;
  assign nb_c[3] = deq_c - ONE;

  always_comb begin
    n_push    = '0;
    goal_hit  = 1'b0;
    push_en   = '0;
    push_slot = '0;
    nb_idx    = '0;
    for (int k = 0; k < 4; k++) begin
      nb_idx[k]    = cell_idx(nb_r[k], nb_c[k]);
      push_slot[k] = tail_q + PTR_W'(n_push);
      push_en[k]   = interior(nb_r[k], nb_c[k]) && !wall_q[nb_idx[k]] && !visited_q[nb_idx[k]];
      if (push_en[k]) begin
        n_push = n_push + 3'd1;
        if (nb_r[k] == GOAL && nb_c[k] == GOAL) goal_hit = 1'b1;
      end
    end
    // Occupancy after this cycle's dequeue plus all pushes.
    overflow = (OCC_W'(occ) - OCC_W'(1) + OCC_W'(n_push)) > OCC_W'(QUEUE_DEPTH);
  end

  always_comb begin
    nxt_r = cur_r_q;
    nxt_c = cur_c_q;
    case (parent_q[cur_idx])
      2'd0:    nxt_r = cur_r_q - ONE;
      2'd1:    nxt_c = cur_c_q - ONE;
      2'd2:    nxt_r = cur_r_q + ONE;
      default: nxt_c = cur_c_q + ONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StLoad;
      beat_q         <= '0;
      wall_q         <= '0;
      visited_q      <= '0;
      parent_q       <= '0;
      queue_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      cur_r_q        <= '0;
      cur_c_q        <= '0;
      primed_q       <= 1'b0;
      out_valid      <= 1'b0;
      maze_not_valid <= 1'b0;
      out_x          <= '0;
      out_y          <= '0;
      out_last       <= 1'b0;
`ifdef MAZE_PATH_LEN_EN
      step_q         <= '0;
      path_len       <= '0;
`endif
    end else begin
      out_valid      <= 1'b0;
      maze_not_valid <= 1'b0;
      out_x          <= '0;
      out_y          <= '0;
      out_last       <= 1'b0;
`ifdef MAZE_PATH_LEN_EN
      path_len       <= '0;
`endif
      case (state_q)
        StLoad: begin
          if (accept) begin
            wall_q[beat_q] <= maze;
            if (beat_q == IDX_W'(CELLS - 1)) begin
              beat_q     <= '0;
              state_q    <= StSearch;
              visited_q  <= START_MASK;
              queue_q[0] <= {ONE, ONE};
              head_q     <= '0;
              tail_q     <= PTR_W'(1);
            end else begin
              beat_q <= beat_q + IDX_W'(1);
            end
          end
        end
        StSearch: begin
          if (blocked || (occ == '0) || overflow) begin
            state_q <= StFail;
          end else begin
            head_q <= head_q + PTR_W'(1);
            tail_q <= tail_q + PTR_W'(n_push);
            for (int k = 0; k < 4; k++) begin
              if (push_en[k]) begin
                queue_q[push_slot[k][QA_W-1:0]] <= {nb_r[k], nb_c[k]};
                visited_q[nb_idx[k]]            <= 1'b1;
                parent_q[nb_idx[k]]             <= 2'(k);
              end
            end
            if (goal_hit) begin
              state_q  <= StTrace;
              primed_q <= 1'b0;
            end
          end
        end
        StTrace: begin
          if (!primed_q) begin
            cur_r_q  <= GOAL;
            cur_c_q  <= GOAL;
            primed_q <= 1'b1;
`ifdef MAZE_PATH_LEN_EN
            step_q   <= '0;
`endif
          end else begin
            out_valid <= 1'b1;
            out_x     <= cur_c_q;
            out_y     <= cur_r_q;
            if (cur_r_q == ONE && cur_c_q == ONE) begin
              out_last <= 1'b1;
              state_q  <= StLoad;
`ifdef MAZE_PATH_LEN_EN
              path_len <= step_q;
`endif
            end else begin
              cur_r_q <= nxt_r;
              cur_c_q <= nxt_c;
`ifdef MAZE_PATH_LEN_EN
              step_q  <= step_q + CW2'(1);
`endif
            end
          end
        end
        default: begin
          out_valid      <= 1'b1;
          maze_not_valid <= 1'b1;
          out_last       <= 1'b1;
          state_q        <= StLoad;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maze_bfs_solver.sv
// Directed bench for maze_bfs_solver: three instances (15/64, 7/4, 7/64) share clock and reset.
module tb_maze_bfs_solver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic maze = 1'b0;
  logic in_valid = 1'b0;
  int   sel = 0;

  logic iv_a, iv_b, iv_c;
  logic ov_a, nv_a, ol_a, ov_b, nv_b, ol_b, ov_c, nv_c, ol_c;
  logic [3:0] x_a, y_a;
  logic [2:0] x_b, y_b, x_c, y_c;
`ifdef MAZE_PATH_LEN_EN
  logic [7:0] pl_a;
  logic [5:0] pl_b, pl_c;
  logic [7:0] pl;
`endif
  logic ov, nv, ol;
  logic [3:0] ox, oy;

  assign iv_a = in_valid && (sel == 0);
  assign iv_b = in_valid && (sel == 1);
  assign iv_c = in_valid && (sel == 2);

  always #5 clk = ~clk;

  maze_bfs_solver #(.SIZE(15), .QUEUE_DEPTH(64)) u_dut_a (
    .clk(clk), .rst(rst), .maze(maze), .in_valid(iv_a), .out_valid(ov_a),
    .maze_not_valid(nv_a), .out_x(x_a), .out_y(y_a), .out_last(ol_a)
`ifdef MAZE_PATH_LEN_EN
    , .path_len(pl_a)
`endif
  );
  maze_bfs_solver #(.SIZE(7), .QUEUE_DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .maze(maze), .in_valid(iv_b), .out_valid(ov_b),
    .maze_not_valid(nv_b), .out_x(x_b), .out_y(y_b), .out_last(ol_b)
`ifdef MAZE_PATH_LEN_EN
    , .path_len(pl_b)
`endif
  );
  maze_bfs_solver #(.SIZE(7), .QUEUE_DEPTH(64)) u_dut_c (
    .clk(clk), .rst(rst), .maze(maze), .in_valid(iv_c), .out_valid(ov_c),
    .maze_not_valid(nv_c), .out_x(x_c), .out_y(y_c), .out_last(ol_c)
`ifdef MAZE_PATH_LEN_EN
    , .path_len(pl_c)
`endif
  );

  always_comb begin
    ov = ov_a; nv = nv_a; ol = ol_a; ox = x_a; oy = y_a;
`ifdef MAZE_PATH_LEN_EN
    pl = pl_a;
`endif
    if (sel == 1) begin
      ov = ov_b; nv = nv_b; ol = ol_b; ox = {1'b0, x_b}; oy = {1'b0, y_b};
`ifdef MAZE_PATH_LEN_EN
      pl = {2'b00, pl_b};
`endif
    end else if (sel == 2) begin
      ov = ov_c; nv = nv_c; ol = ol_c; ox = {1'b0, x_c}; oy = {1'b0, y_c};
`ifdef MAZE_PATH_LEN_EN
      pl = {2'b00, pl_c};
`endif
    end
  end

  int checks = 0;
  int passed = 0;
  bit m [15][15];
  int sz = 15;
  int px[$];
  int py[$];
  int nbeats, nv_cnt, last_cnt, fx, fy, lx, ly, plen_last, plen_bad;
  bit timeout, gap;

  task automatic clear_grid(input int n, input bit border);
    sz = n;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++)
        m[r][c] = border && (r == 0 || c == 0 || r == n - 1 || c == n - 1);
  endtask

  task automatic serp_rows();
    clear_grid(15, 1'b1);
    for (int r = 2; r <= 12; r += 2) begin
      for (int c = 1; c <= 13; c++) m[r][c] = 1'b1;
      m[r][((r / 2) % 2 == 1) ? 13 : 1] = 1'b0;
    end
  endtask

  task automatic serp_cols();
    clear_grid(15, 1'b1);
    for (int c = 2; c <= 12; c += 2) begin
      for (int r = 1; r <= 13; r++) m[r][c] = 1'b1;
      m[((c / 2) % 2 == 1) ? 13 : 1][c] = 1'b0;
    end
  endtask

  task automatic load_maze(input bit keep_valid);
    for (int r = 0; r < sz; r++)
      for (int c = 0; c < sz; c++) begin
        @(negedge clk);
        maze = m[r][c];
        in_valid = 1'b1;
      end
    @(negedge clk);
    maze = keep_valid;
    in_valid = keep_valid;
  endtask

  task automatic collect(input int budget);
    int waited;
    bit done, started;
    px.delete(); py.delete();
    nbeats = 0; nv_cnt = 0; last_cnt = 0; plen_last = -1; plen_bad = 0;
    fx = -1; fy = -1; lx = -1; ly = -1;
    timeout = 0; gap = 0; waited = 0; done = 0; started = 0;
    while (!done) begin
      @(negedge clk);
      if (ov) begin
        if (!started) begin fx = int'(ox); fy = int'(oy); end
        started = 1;
        px.push_back(int'(ox)); py.push_back(int'(oy));
        nbeats++; lx = int'(ox); ly = int'(oy);
        if (nv) nv_cnt++;
`ifdef MAZE_PATH_LEN_EN
        if (ol) plen_last = int'(pl);
        else if (pl != 0) plen_bad++;
`endif
        if (ol) begin last_cnt++; done = 1; end
      end else if (started) begin
        gap = 1; done = 1;
      end else begin
        waited++;
        if (waited > budget) begin timeout = 1; done = 1; end
      end
    end
  endtask

  task automatic path_bad(output int bad);
    int dx, dy;
    bad = 0;
    foreach (px[i]) begin
      if (px[i] <= 0 || py[i] <= 0 || px[i] >= sz - 1 || py[i] >= sz - 1 || m[py[i]][px[i]])
        bad++;
      else if (i > 0) begin
        dx = px[i] - px[i-1]; dy = py[i] - py[i-1];
        if (((dx < 0) ? -dx : dx) + ((dy < 0) ? -dy : dy) != 1) bad++;
      end
    end
  endtask

  // Checks shared shape of a successful path of expected beat count ending at (g,g).
  task automatic check_success(input string tag, input int want_len, input int g);
    int bad;
    path_bad(bad);
    checks++; if (timeout !== 1'b0) $display("FAIL %s_timeout: no beat seen", tag); else passed++;
    checks++; if (gap !== 1'b0) $display("FAIL %s_gap: out_valid dropped early", tag); else passed++;
    checks++; if (nbeats !== want_len) $display("FAIL %s_len: got %0d want %0d", tag, nbeats, want_len); else passed++;
    checks++; if (fx !== g || fy !== g) $display("FAIL %s_first: got (%0d,%0d) want (%0d,%0d)", tag, fx, fy, g, g); else passed++;
    checks++; if (lx !== 1 || ly !== 1) $display("FAIL %s_last: got (%0d,%0d) want (1,1)", tag, lx, ly); else passed++;
    checks++; if (nv_cnt !== 0) $display("FAIL %s_notvalid: got %0d want 0", tag, nv_cnt); else passed++;
    checks++; if (last_cnt !== 1) $display("FAIL %s_lastcnt: got %0d want 1", tag, last_cnt); else passed++;
    checks++; if (bad !== 0) $display("FAIL %s_steps: got %0d bad cells want 0", tag, bad); else passed++;
`ifdef MAZE_PATH_LEN_EN
    checks++; if (plen_last !== want_len - 1) $display("FAIL %s_path_len: got %0d want %0d", tag, plen_last, want_len - 1); else passed++;
    checks++; if (plen_bad !== 0) $display("FAIL %s_path_len_early: got %0d want 0", tag, plen_bad); else passed++;
`endif
  endtask

  task automatic check_fail(input string tag);
    checks++; if (timeout !== 1'b0) $display("FAIL %s_timeout: no beat seen", tag); else passed++;
    checks++; if (nbeats !== 1) $display("FAIL %s_beats: got %0d want 1", tag, nbeats); else passed++;
    checks++; if (nv_cnt !== 1) $display("FAIL %s_notvalid: got %0d want 1", tag, nv_cnt); else passed++;
    checks++; if (last_cnt !== 1) $display("FAIL %s_last: got %0d want 1", tag, last_cnt); else passed++;
    checks++; if (fx !== 0 || fy !== 0) $display("FAIL %s_xy: got (%0d,%0d) want (0,0)", tag, fx, fy); else passed++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({ov_a, nv_a, ol_a, x_a, y_a} !== 11'b0) $display("FAIL reset_outputs: got %b want 0", {ov_a, nv_a, ol_a, x_a, y_a}); else passed++;
`ifdef MAZE_PATH_LEN_EN
    checks++; if (pl_a !== 8'd0) $display("FAIL reset_path_len: got %0d want 0", pl_a); else passed++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_open15();
    sel = 0; clear_grid(15, 1'b1);
    load_maze(1'b0); collect(2000);
    check_success("open15", 25, 13);
  endtask

  task automatic test_start_wall();
    sel = 0; clear_grid(15, 1'b1); m[1][1] = 1'b1;
    load_maze(1'b0);
    checks++; if (ov !== 1'b0) $display("FAIL startwall_e1: got out_valid %b want 0", ov); else passed++;
    @(negedge clk);
    checks++; if (ov !== 1'b0) $display("FAIL startwall_e2: got out_valid %b want 0", ov); else passed++;
    @(negedge clk);
    checks++; if ({ov, nv, ol, ox, oy} !== 11'b111_0000_0000) $display("FAIL startwall_beat: got %b want 11100000000", {ov, nv, ol, ox, oy}); else passed++;
    @(negedge clk);
    checks++; if (ov !== 1'b0) $display("FAIL startwall_after: got out_valid %b want 0", ov); else passed++;
  endtask

  task automatic test_row_wall();
    sel = 0; clear_grid(15, 1'b1);
    for (int c = 0; c < 15; c++) m[7][c] = 1'b1;
    load_maze(1'b0); collect(2000);
    check_fail("rowwall");
    @(negedge clk);
    checks++; if (ov !== 1'b0) $display("FAIL rowwall_single: got out_valid %b want 0", ov); else passed++;
  endtask

  task automatic test_overflow();
    sel = 1; clear_grid(7, 1'b0);
    load_maze(1'b0); collect(500);
    check_fail("overflow");
  endtask

  task automatic test_small_deep();
    sel = 2; clear_grid(7, 1'b0);
    load_maze(1'b0); collect(500);
    check_success("small64", 9, 5);
  endtask

  task automatic test_back_to_back();
    sel = 0; serp_rows();
    load_maze(1'b1); collect(2000);
    check_success("serp_rows", 97, 13);
    serp_cols();
    load_maze(1'b0); collect(2000);
    check_success("serp_cols", 97, 13);
  endtask

  task automatic test_reset_trace();
    int seen, waited;
    sel = 0; clear_grid(15, 1'b1);
    load_maze(1'b0);
    seen = 0; waited = 0;
    while (seen < 5 && waited < 2000) begin
      @(negedge clk);
      waited++;
      if (ov) seen++;
    end
    checks++; if (seen !== 5) $display("FAIL rsttrace_reach: got %0d beats want 5", seen); else passed++;
    rst = 1'b1;
    #1;
    checks++; if ({ov, nv, ol, ox, oy} !== 11'b0) $display("FAIL rsttrace_clear: got %b want 0", {ov, nv, ol, ox, oy}); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ov !== 1'b0) $display("FAIL rsttrace_idle: got out_valid %b want 0", ov); else passed++;
    serp_rows();
    load_maze(1'b0); collect(2000);
    check_success("rsttrace_fresh", 97, 13);
  endtask

  initial begin
    test_reset();
    test_open15();
    test_start_wall();
    test_row_wall();
    test_overflow();
    test_small_deep();
    test_back_to_back();
    test_reset_trace();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
